// File: rtl/pool_pkg.sv
// Shared types and constants for the max_pool layer engine.
// Selecting average pooling (MAX_POOL_AVG_EN) only affects pool_combine.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_PARAM,
        LD_WAIT,
        CHECK,
        EVAL,
        DRAIN,
        DONE
    } state_t;

    // Layer parameter words: width, height, depth
    localparam int PARAM_NUM = 3;

    localparam logic [17:0] DEF_PARAM_BASE    = 18'd0;
    localparam logic [17:0] DEF_FMAP_IN_BASE  = 18'd131072;
    localparam logic [17:0] DEF_FMAP_OUT_BASE = 18'd196608;

    // Window phase: bit 0 selects the odd column, bit 1 selects the odd row
    localparam logic [1:0] PH_FIRST = 2'd0;
    localparam logic [1:0] PH_LAST  = 2'd3;

    // Feature-map word offset: channel, row, column packed into 18 bits
    function automatic logic [17:0] pack_addr(input logic [3:0] c,
                                              input logic [4:0] y,
                                              input logic [4:0] x);
        return {4'b0, c, y, x};
    endfunction

endpackage

// File: rtl/max_pool_if.sv
// DRAM port of the layer engines: one read and one write address per cycle,
// read data returned one cycle after the read enable.
interface max_pool_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
);
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  dram_en_rd;
    logic                  dram_en_wr;

    modport master (
        input  dram_valid, data_in,
        output data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
    );

    modport slave (
        output dram_valid, data_in,
        input  data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
    );
endinterface

// File: rtl/pool_combine.sv
// Window combine step: signed max by default, or average when MAX_POOL_AVG_EN
// is defined (sum of four, arithmetic shift right by two, floor rounding).
module pool_combine
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_W      = DATA_WIDTH + 2
) (
    input  logic [ACC_W-1:0]      acc,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  first,
    input  logic                  last,
    output logic [ACC_W-1:0]      acc_nx,
    output logic [DATA_WIDTH-1:0] result
);
    logic signed [ACC_W-1:0] din_sx;
    logic signed [ACC_W-1:0] comb;

    assign din_sx = ACC_W'($signed(data_in));

`ifdef MAX_POOL_AVG_EN
    // Two guard bits keep the sum of four words exact
    assign comb   = $signed(acc) + din_sx;
    assign result = DATA_WIDTH'(comb >>> 2);
`else
    // Strict greater-than: on a tie the accumulator is kept
    assign comb   = (din_sx > $signed(acc)) ? din_sx : $signed(acc);
    assign result = DATA_WIDTH'(comb);
`endif

    assign acc_nx = first ? din_sx : (last ? acc : comb);

endmodule

// File: rtl/max_pool.sv
// max_pool: 2x2 stride-2 pooling of a DRAM feature map, one read per cycle.
// Max pooling by default; define MAX_POOL_AVG_EN for average pooling.
module max_pool
    import pool_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 18,
    parameter logic [ADDR_WIDTH-1:0] PARAM_BASE    = ADDR_WIDTH'(DEF_PARAM_BASE),
    parameter logic [ADDR_WIDTH-1:0] FMAP_IN_BASE  = ADDR_WIDTH'(DEF_FMAP_IN_BASE),
    parameter logic [ADDR_WIDTH-1:0] FMAP_OUT_BASE = ADDR_WIDTH'(DEF_FMAP_OUT_BASE)
) (
    input  logic       clk,
    input  logic       srstn,
    input  logic       enable,
    output logic       done,
    max_pool_if.master dram
);
    localparam int ACC_W = DATA_WIDTH + 2;

    state_t state, state_nx;

    logic [1:0] pcnt;
    logic [5:0] width, height, depth;

    // Read-side window counters and their one-cycle-delayed write-side copies
    logic [1:0] ph,   ph_d;
    logic [4:0] ox,   ox_d;
    logic [4:0] oy,   oy_d;
    logic [3:0] oc,   oc_d;
    logic       val_d;

    logic [4:0] ow_last, oh_last;
    logic [3:0] oc_last;
    logic       win_last, geom_bad;

    logic [ACC_W-1:0]      acc, acc_nx;
    logic [DATA_WIDTH-1:0] result;
    logic                  wr_en;

    logic unused_dram_valid;
    assign unused_dram_valid = dram.dram_valid;

    assign ow_last  = width[5:1] - 5'd1;
    assign oh_last  = height[5:1] - 5'd1;
    assign oc_last  = 4'(depth - 6'd1);
    assign win_last = (ph == PH_LAST) && (ox == ow_last) && (oy == oh_last) && (oc == oc_last);
    assign geom_bad = (width < 6'd2) || (height < 6'd2) || (depth == 6'd0);

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them see pre-edge values; reset is synchronous.
        if (!srstn) begin
            state  <= IDLE;
            pcnt   <= '0;
            width  <= '0;
            height <= '0;
            depth  <= '0;
            ph     <= '0;
            ox     <= '0;
            oy     <= '0;
            oc     <= '0;
            ph_d   <= '0;
            ox_d   <= '0;
            oy_d   <= '0;
            oc_d   <= '0;
            val_d  <= 1'b0;
            acc    <= '0;
        end else begin
            state <= state_nx;
            val_d <= (state == EVAL);
            ph_d  <= ph;
            ox_d  <= ox;
            oy_d  <= oy;
            oc_d  <= oc;
            if (val_d) acc <= acc_nx;

            case (state)
                LD_PARAM: begin
                    pcnt <= (pcnt == 2'(PARAM_NUM - 1)) ? 2'd0 : pcnt + 2'd1;
                    if (pcnt == 2'd1) width  <= dram.data_in[5:0];
                    if (pcnt == 2'd2) height <= dram.data_in[5:0];
                end
                LD_WAIT: depth <= dram.data_in[5:0];
                EVAL: begin
                    ph <= ph + 2'd1;
                    if (ph == PH_LAST) begin
                        if (ox == ow_last) begin
                            ox <= '0;
                            if (oy == oh_last) begin
                                oy <= '0;
                                oc <= (oc == oc_last) ? 4'd0 : oc + 4'd1;
                            end else begin
                                oy <= oy + 5'd1;
                            end
                        end else begin
                            ox <= ox + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case can infer a latch.
        state_nx        = state;
        dram.dram_en_rd = 1'b0;
        dram.addr_in    = '0;
        unique case (state)
            IDLE:     if (enable) state_nx = LD_PARAM;
            LD_PARAM: begin
                dram.dram_en_rd = 1'b1;
                dram.addr_in    = PARAM_BASE + ADDR_WIDTH'(pcnt);
                if (pcnt == 2'(PARAM_NUM - 1)) state_nx = LD_WAIT;
            end
            LD_WAIT:  state_nx = CHECK;
            CHECK:    state_nx = geom_bad ? DONE : EVAL;
            EVAL: begin
                dram.dram_en_rd = 1'b1;
                dram.addr_in    = FMAP_IN_BASE +
                                  ADDR_WIDTH'(pack_addr(oc, {oy[3:0], ph[1]}, {ox[3:0], ph[0]}));
                if (win_last) state_nx = DRAIN;
            end
            DRAIN:    state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    pool_combine #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W)
    ) u_combine (
        .acc     (acc),
        .data_in (dram.data_in),
        .first   (ph_d == PH_FIRST),
        .last    (ph_d == PH_LAST),
        .acc_nx  (acc_nx),
        .result  (result)
    );

    // The final window of a layer is written during DRAIN
    assign wr_en           = val_d && (ph_d == PH_LAST);
    assign dram.dram_en_wr = wr_en;
    assign dram.data_out   = wr_en ? result : '0;
    assign dram.addr_out   = wr_en ? FMAP_OUT_BASE + ADDR_WIDTH'(pack_addr(oc_d, oy_d, ox_d)) : '0;
    assign done            = (state == DONE);

endmodule

// File: tb/tb_max_pool.sv
// Scoreboard bench for max_pool: a window-level reference model queues the
// expected writes, and a monitor compares each DRAM write as it appears.
module tb_max_pool;
    localparam int DW       = 32;
    localparam int AW       = 18;
    localparam int IN_BASE  = 131072;
    localparam int OUT_BASE = 196608;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic srstn;
    logic enable;
    logic done;

    max_pool_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    max_pool #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .PARAM_BASE    (18'd0),
        .FMAP_IN_BASE  (18'd131072),
        .FMAP_OUT_BASE (18'd196608)
    ) dut (
        .clk    (clk),
        .srstn  (srstn),
        .enable (enable),
        .done   (done),
        .dram   (bus.master)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    wr_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_param, rd_eval, bad_rd;
    int cur_ow, cur_oh, cur_d;
    int exp_n, exp_cycles, start_cyc;

    // DRAM model: fixed one-cycle read latency
    assign bus.dram_valid = 1'b0;
    always @(posedge clk) begin
        cyc++;
        if (bus.dram_en_rd) bus.data_in <= mem[bus.addr_in];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: read-range bookkeeping and scoreboard comparison of writes
    always @(negedge clk) begin
        int a, x, y, c;
        wr_t e;
        if (bus.dram_en_rd) begin
            if (int'(bus.addr_in) < 3) rd_param++;
            else begin
                rd_eval++;
                a = int'(bus.addr_in) - IN_BASE;
                x = a & 31;
                y = (a >> 5) & 31;
                c = (a >> 10) & 15;
                if (a < 0 || (a >> 14) != 0 || x >= 2 * cur_ow || y >= 2 * cur_oh || c >= cur_d)
                    bad_rd++;
            end
        end
        if (bus.dram_en_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_write: got addr 0x%05h data 0x%08h, expected no write",
                         bus.addr_out, bus.data_out);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.addr_out), 32'(e.addr));
                check("wr_data", bus.data_out, e.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr_in"},  32'(bus.addr_in),  0);
        check({tag, "_addr_out"}, 32'(bus.addr_out), 0);
        check({tag, "_en_rd"},    32'(bus.dram_en_rd), 0);
        check({tag, "_en_wr"},    32'(bus.dram_en_wr), 0);
        check({tag, "_done"},     32'(done), 0);
        check({tag, "_data_out"}, bus.data_out, 0);
    endtask

    // fill: 0 = full-range random, 1 = ramp, 2 = preloaded by caller, 3 = small random (ties)
    task automatic prep_layer(input int w, input int h, input int d, input int fill);
        int ow, oh;
        mem[0] = DW'(w);
        mem[1] = DW'(h);
        mem[2] = DW'(d);
        if (fill != 2)
            for (int c = 0; c < d; c++)
                for (int y = 0; y < h; y++)
                    for (int x = 0; x < w; x++)
                        mem[IN_BASE + (c << 10) + (y << 5) + x] =
                            (fill == 1) ? DW'(y * w + x + c * 100) :
                            (fill == 3) ? DW'(int'($urandom_range(0, 7)) - 4) : DW'($urandom);
        ow = w / 2;
        oh = h / 2;
        for (int c = 0; c < d; c++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++) begin
                    int v[4];
                    int m;
                    longint s, q;
                    wr_t e;
                    for (int k = 0; k < 4; k++)
                        v[k] = $signed(mem[IN_BASE + (c << 10) + ((2 * oy + k / 2) << 5) + 2 * ox + k % 2]);
`ifdef MAX_POOL_AVG_EN
                    s = longint'(v[0]) + longint'(v[1]) + longint'(v[2]) + longint'(v[3]);
                    q = s / 4;
                    if (s < 0 && (s % 4) != 0) q = q - 1;
                    m = int'(q);
`else
                    m = v[0];
                    for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
                    s = 0;
                    q = 0;
`endif
                    e.addr = AW'(OUT_BASE + (c << 10) + (oy << 5) + ox);
                    e.data = DW'(m);
                    exp_q.push_back(e);
                end
        cur_ow = ow;
        cur_oh = oh;
        cur_d  = d;
        exp_n  = ow * oh * d;
        exp_cycles = (ow == 0 || oh == 0 || d == 0) ? 7 : 8 + 4 * exp_n;
        rd_param = 0;
        rd_eval  = 0;
        bad_rd   = 0;
    endtask

    task automatic start_run(input bit hold);
        @(negedge clk);
        enable = 1'b1;
        start_cyc = cyc;
        if (!hold) begin
            @(negedge clk);
            enable = 1'b0;
        end
    endtask

    task automatic finish_run(input string tag);
        bit got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            if (done) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: done not seen, required within 5000 cycles", tag);
            enable = 1'b0;
            exp_q.delete();
            return;
        end
        check({tag, "_latency"}, 32'(cyc - start_cyc + 1), 32'(exp_cycles));
        enable = 1'b0;
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 0);
        check({tag, "_bad_reads"}, 32'(bad_rd), 0);
        check({tag, "_param_reads"}, 32'(rd_param), 3);
        check({tag, "_eval_reads"}, 32'(rd_eval), 32'(4 * exp_n));
    endtask

    task automatic run_layer(input string tag, input int w, input int h, input int d, input int fill);
        prep_layer(w, h, d, fill);
        start_run(1'b0);
        finish_run(tag);
    endtask

    initial begin
        int base;
        srstn  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        srstn = 1'b1;
        @(negedge clk);

        run_layer("ramp4x4", 4, 4, 1, 1);
        run_layer("odd5x3x2", 5, 3, 2, 1);

        mem[IN_BASE + 0]  = -32'sd7;
        mem[IN_BASE + 1]  = -32'sd3;
        mem[IN_BASE + 32] = -32'sd100;
        mem[IN_BASE + 33] = 32'h8000_0000;
        run_layer("signed_win", 2, 2, 1, 2);

        run_layer("width1", 1, 4, 1, 1);
        run_layer("depth0", 4, 4, 0, 1);
        run_layer("height1", 6, 1, 2, 1);
        run_layer("wide32", 32, 2, 1, 0);
        run_layer("deep16", 2, 2, 16, 0);

        prep_layer(4, 2, 1, 0);
        start_run(1'b1);
        finish_run("hold_en");

        // Reset in the middle of EVAL, then a clean rerun
        prep_layer(4, 4, 2, 0);
        start_run(1'b0);
        base = wr_cnt;
        for (int i = 0; i < 2000 && wr_cnt < base + 2; i++) @(negedge clk);
        check("midrst_writes_before", 32'(wr_cnt - base), 2);
        srstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        srstn = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_more_writes", 32'(wr_cnt - base), 2);
        run_layer("rerun", 4, 4, 2, 0);

        for (int r = 0; r < 6; r++)
            run_layer("rand", int'($urandom_range(2, 12)), int'($urandom_range(2, 12)),
                      int'($urandom_range(1, 3)), (r % 2 == 0) ? 0 : 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required the bench to finish first");
        $fatal(1, "watchdog");
    end

endmodule
